// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter.
//   state_t : FSM encoding (IDLE / ACCESS / RESP)
//   owner_t : which requester owns the current access
//   acc_t   : latched access (write flag, address, write data)
package mem_arbiter_pkg;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_DM = 1'b1
   } owner_t;

   typedef struct packed {
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } acc_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Priority select between fetch (IF) and data (DM) requests, with a
// starvation counter that forces IF to win after STARVE_MAX consecutive
// DM grants taken while IF was waiting.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   if_req, dm_req    raw requests
//   grant             high in the cycle the top commits to the pick
//   owner             0 = IF, 1 = DM (combinational)
//   any_req           at least one request pending
module mem_arb_pick
   import mem_arbiter_pkg::*;
#(
   parameter int STARVE_MAX = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic if_req,
   input  logic dm_req,
   input  logic grant,
   output logic owner,
   output logic any_req
);

   localparam logic [2:0] SMAX = 3'(STARVE_MAX);

   logic [2:0] starve;

   always_comb begin
      any_req = if_req | dm_req;
      if (dm_req && starve < SMAX) owner = OWN_DM;
      else if (if_req)             owner = OWN_IF;
      else                         owner = OWN_DM;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve <= '0;
      end else if (grant) begin
         if (owner == OWN_IF)
            starve <= '0;
         else if (if_req && starve != 3'd7)
            starve <= starve + 3'd1;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port 16-bit memory. Each access
// holds mem_enable for MEM_LAT cycles, then a RESP cycle pulses the
// owner's ready. All outputs are registered.
// Optional feature macro: ALIGN_CHECK_EN -- rejects odd addresses in IDLE
// with an err pulse (err port exists only when defined).
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   if_req/if_addr -> if_ready/if_rdata   fetch port (read only)
//   dm_req/dm_wr/dm_addr/dm_wdata -> dm_ready/dm_rdata   data port
//   mem_enable/mem_wr/mem_addr/mem_wdata, mem_rdata      memory side
//   busy                               FSM not in IDLE
//   err                                rejected-request pulse (optional)
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int MEM_LAT    = 1,
   parameter int STARVE_MAX = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_req,
   input  logic [15:0] if_addr,
   output logic        if_ready,
   output logic [15:0] if_rdata,
   input  logic        dm_req,
   input  logic        dm_wr,
   input  logic [15:0] dm_addr,
   input  logic [15:0] dm_wdata,
   output logic        dm_ready,
   output logic [15:0] dm_rdata,
   output logic        mem_enable,
   output logic        mem_wr,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   output logic        busy
`ifdef ALIGN_CHECK_EN
   ,
   output logic        err
`endif
);

   localparam logic [2:0] LAT0 = 3'(MEM_LAT - 1);

   state_t state, state_nx;
   owner_t owner_q, owner_nx;
   acc_t   lat_q, lat_nx, sel;
   logic [2:0] cnt, cnt_nx;
   logic   grant, resp, rd_done;
   logic   pick_owner, any_req;
   logic   sel_odd, hold_off;

   mem_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
      .clk     (clk),
      .rst_n   (rst_n),
      .if_req  (if_req),
      .dm_req  (dm_req),
      .grant   (grant),
      .owner   (pick_owner),
      .any_req (any_req)
   );

   always_comb begin
      sel.wr    = pick_owner & dm_wr;
      sel.addr  = pick_owner ? dm_addr  : if_addr;
      sel.wdata = pick_owner ? dm_wdata : '0;
   end

`ifdef ALIGN_CHECK_EN
   assign sel_odd  = sel.addr[0];
   // A reject's ready is visible while still in IDLE; skip one sample so
   // the requester's held request is not rejected twice.
   assign hold_off = err;
`else
   assign sel_odd  = 1'b0;
   assign hold_off = 1'b0;
`endif

   always_comb begin
      state_nx = state;
      owner_nx = owner_q;
      lat_nx   = lat_q;
      cnt_nx   = cnt;
      grant    = 1'b0;
      resp     = 1'b0;
      rd_done  = 1'b0;
      case (state)
         IDLE: begin
            if (any_req && !hold_off) begin
               grant    = 1'b1;
               owner_nx = owner_t'(pick_owner);
               if (sel_odd) begin
                  resp = 1'b1;
               end else begin
                  lat_nx   = sel;
                  cnt_nx   = LAT0;
                  state_nx = ACCESS;
               end
            end
         end
         ACCESS: begin
            if (cnt == 3'd0) begin
               rd_done  = ~lat_q.wr;
               resp     = 1'b1;
               state_nx = RESP;
            end else begin
               cnt_nx = cnt - 3'd1;
            end
         end
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         owner_q    <= OWN_IF;
         lat_q      <= '0;
         cnt        <= '0;
         mem_enable <= 1'b0;
         mem_wr     <= 1'b0;
         busy       <= 1'b0;
         if_ready   <= 1'b0;
         dm_ready   <= 1'b0;
         if_rdata   <= '0;
         dm_rdata   <= '0;
      end else begin
         state      <= state_nx;
         owner_q    <= owner_nx;
         lat_q      <= lat_nx;
         cnt        <= cnt_nx;
         mem_enable <= (state_nx == ACCESS);
         // Strobe only in the last ACCESS cycle: one write edge per access.
         mem_wr     <= (state_nx == ACCESS) && (cnt_nx == 3'd0) && lat_nx.wr;
         busy       <= (state_nx != IDLE);
         if_ready   <= resp && (owner_nx == OWN_IF);
         dm_ready   <= resp && (owner_nx == OWN_DM);
         if (rd_done) begin
            if (owner_q == OWN_IF) if_rdata <= mem_rdata;
            else                   dm_rdata <= mem_rdata;
         end
      end
   end

`ifdef ALIGN_CHECK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err <= 1'b0;
      else        err <= grant && sel_odd;
   end
`endif

   assign mem_addr  = lat_q.addr;
   assign mem_wdata = lat_q.wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

   localparam int LAT = 3;
   localparam int SMX = 3;

   logic        clk, rst_n;
   logic        if_req, if_ready, dm_req, dm_wr, dm_ready;
   logic [15:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata;
   logic        mem_enable, mem_wr, busy;
   logic [15:0] mem_addr, mem_wdata, mem_rdata, addr1;
`ifdef ALIGN_CHECK_EN
   logic        err;
`endif

   mem_arbiter #(.MEM_LAT(LAT), .STARVE_MAX(SMX)) u_dut (
`ifdef ALIGN_CHECK_EN
      .err(err),
`endif
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_ready(dm_ready), .dm_rdata(dm_rdata),
      .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Byte-addressed memory model; second byte wraps at 0xFFFF.
   logic [7:0]  mem  [0:65535];
   logic [7:0]  rmem [0:65535];
   logic        pre_we;
   logic [15:0] pre_addr;
   logic [7:0]  pre_data;

   assign addr1     = mem_addr + 16'd1;
   assign mem_rdata = {mem[mem_addr], mem[addr1]};

   always @(posedge clk) begin
      if (pre_we) mem[pre_addr] <= pre_data;
      else if (mem_enable && mem_wr) begin
         mem[mem_addr] <= mem_wdata[15:8];
         mem[addr1]    <= mem_wdata[7:0];
      end
   end

   typedef struct {bit dm; bit wr; logic [15:0] data;} exp_t;
   exp_t sb[$];
   int checks = 0;
   int errors = 0;
   logic [15:0] exp_if, exp_dm;

   task automatic preload(input logic [15:0] a, input logic [15:0] d);
      logic [15:0] a1;
      a1 = a + 16'd1;
      @(posedge clk); #1;
      pre_we = 1'b1; pre_addr = a;  pre_data = d[15:8];
      @(posedge clk); #1;
      pre_addr = a1; pre_data = d[7:0];
      @(posedge clk); #1;
      pre_we = 1'b0;
      rmem[a] = d[15:8];
      rmem[a1] = d[7:0];
   endtask

   task automatic push(input bit dm, input bit wr, input logic [15:0] a, input logic [15:0] d);
      exp_t e;
      logic [15:0] a1;
      a1 = a + 16'd1;
      e.dm = dm; e.wr = wr; e.data = wr ? 16'h0 : {rmem[a], rmem[a1]};
      if (wr) begin
         rmem[a] = d[15:8];
         rmem[a1] = d[7:0];
      end
      sb.push_back(e);
   endtask

   task automatic test_reset;
      rst_n = 1'b0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
      if_req = 0; if_addr = '0; dm_req = 0; dm_wr = 0; dm_addr = '0; dm_wdata = '0;
      repeat (2) @(negedge clk);
      checks++;
      if ({if_ready, dm_ready, mem_enable, mem_wr, busy} !== 5'b0) begin
         errors++; $display("FAIL reset_ctrl got=%b want=00000", {if_ready, dm_ready, mem_enable, mem_wr, busy});
      end
      checks++;
      if ({if_rdata, dm_rdata, mem_addr, mem_wdata} !== 64'h0) begin
         errors++; $display("FAIL reset_data got=%h want=0", {if_rdata, dm_rdata, mem_addr, mem_wdata});
      end
      @(posedge clk); #1 rst_n = 1'b1;
   endtask

   // One access from a single port; checks latency, enable/strobe counts,
   // busy, and that ready is a one-cycle pulse.
   task automatic run_access(input bit dm, input bit wr, input logic [15:0] a, input logic [15:0] d);
      int en_cnt, wr_cnt, k;
      bit seen, rdy;
      push(dm, wr, a, d);
      @(posedge clk); #1;
      if (dm) begin dm_req = 1; dm_wr = wr; dm_addr = a; dm_wdata = d; end
      else    begin if_req = 1; if_addr = a; end
      @(posedge clk);
      en_cnt = 0; wr_cnt = 0; seen = 0;
      for (k = 1; k <= 20 && !seen; k++) begin
         @(negedge clk);
         en_cnt += int'(mem_enable);
         wr_cnt += int'(mem_wr);
         checks++;
         if (busy !== 1'b1) begin errors++; $display("FAIL busy_k%0d got=%b want=1", k, busy); end
         rdy = dm ? dm_ready : if_ready;
         if (rdy) begin
            seen = 1;
            checks++;
            if (k != LAT + 1) begin errors++; $display("FAIL latency got=%0d want=%0d", k, LAT + 1); end
            if (dm) dm_req = 0; else if_req = 0;
         end
      end
      checks++;
      if (!seen) begin errors++; $display("FAIL ready_timeout addr=%h", a); end
      checks++;
      if (en_cnt != LAT || wr_cnt != int'(wr)) begin
         errors++; $display("FAIL en_wr_cycles got=%0d/%0d want=%0d/%0d", en_cnt, wr_cnt, LAT, int'(wr));
      end
      @(negedge clk);
      checks++;
      if ({if_ready, dm_ready, busy} !== 3'b0) begin
         errors++; $display("FAIL after_resp got=%b want=000", {if_ready, dm_ready, busy});
      end
   endtask

   task automatic test_if_read;
      preload(16'h0010, 16'h1234);
      run_access(0, 0, 16'h0010, 16'h0);
   endtask

   task automatic test_write_read;
      run_access(1, 1, 16'h0020, 16'hBEEF);
      run_access(1, 0, 16'h0020, 16'h0);
`ifndef ALIGN_CHECK_EN
      run_access(1, 1, 16'hFFFF, 16'hCAFE);
      run_access(0, 0, 16'hFFFF, 16'h0);
`endif
   endtask

   task automatic test_starve;
      int n;
      for (int i = 0; i < 2; i++) begin
         for (int j = 0; j < SMX; j++) push(1, 0, 16'h0020, 16'h0);
         push(0, 0, 16'h0010, 16'h0);
      end
      @(posedge clk); #1;
      dm_req = 1; dm_wr = 0; dm_addr = 16'h0020; if_req = 1; if_addr = 16'h0010;
      n = 0;
      for (int k = 0; k < 200 && n < 8; k++) begin
         @(negedge clk);
         if (if_ready || dm_ready) n++;
         if (n == 8) begin dm_req = 0; if_req = 0; end
      end
      checks++;
      if (n != 8) begin errors++; $display("FAIL starve_count got=%0d want=8", n); dm_req = 0; if_req = 0; end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_withdraw;
      int dm_k, if_k;
      push(1, 0, 16'h0010, 16'h0);
      push(0, 0, 16'h0020, 16'h0);
      @(posedge clk); #1;
      dm_req = 1; dm_wr = 0; dm_addr = 16'h0010; if_req = 1; if_addr = 16'h0020;
      @(posedge clk);
      dm_k = 0; if_k = 0;
      for (int k = 1; k <= 30 && if_k == 0; k++) begin
         @(negedge clk);
         if (k == 1) dm_req = 0;
         if (dm_ready) dm_k = k;
         if (if_ready) begin if_k = k; if_req = 0; end
      end
      checks++;
      if (dm_k != LAT + 1) begin errors++; $display("FAIL withdraw_dm_ready got=%0d want=%0d", dm_k, LAT + 1); end
      checks++;
      if (if_k != 2 * LAT + 3) begin errors++; $display("FAIL withdraw_if_ready got=%0d want=%0d", if_k, 2 * LAT + 3); end
      if_req = 0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset_mid_write;
      preload(16'h0040, 16'hA55A);
      @(posedge clk); #1;
      dm_req = 1; dm_wr = 1; dm_addr = 16'h0040; dm_wdata = 16'h5555;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (mem_enable !== 1'b1) begin errors++; $display("FAIL rst_mid_pre_en got=%b want=1", mem_enable); end
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({mem_enable, mem_wr, busy} !== 3'b0) begin
         errors++; $display("FAIL rst_mid_drop got=%b want=000", {mem_enable, mem_wr, busy});
      end
      dm_req = 0; dm_wr = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if (dm_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_ready got=%b want=0", dm_ready); end
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({mem[16'h0040], mem[16'h0041]} !== 16'hA55A) begin
         errors++; $display("FAIL rst_mid_mem got=%h want=a55a", {mem[16'h0040], mem[16'h0041]});
      end
      checks++;
      if ({if_rdata, dm_rdata} !== 32'h0) begin
         errors++; $display("FAIL rst_mid_rdata got=%h want=0", {if_rdata, dm_rdata});
      end
      run_access(1, 0, 16'h0040, 16'h0);
   endtask

`ifdef ALIGN_CHECK_EN
   task automatic test_align;
      exp_t e;
      e.dm = 1; e.wr = 1; e.data = 16'h0;   // rdata must stay put
      sb.push_back(e);
      @(posedge clk); #1;
      dm_req = 1; dm_wr = 0; dm_addr = 16'h0031;
      @(posedge clk);
      @(negedge clk);
      dm_req = 0;
      checks++;
      if ({err, dm_ready, mem_enable} !== 3'b110) begin
         errors++; $display("FAIL align_reject got=%b want=110", {err, dm_ready, mem_enable});
      end
      @(negedge clk);
      checks++;
      if ({err, dm_ready, busy} !== 3'b0) begin errors++; $display("FAIL align_after got=%b want=000", {err, dm_ready, busy}); end
   endtask
`endif

   initial begin
      exp_if = '0; exp_dm = '0;
      fork
         // Scoreboard consumer: every ready pops one expected response.
         forever begin
            @(negedge clk);
            if (!rst_n) begin
               exp_if = '0; exp_dm = '0;
            end else if (if_ready || dm_ready) begin
               checks++;
               if (sb.size() == 0) begin
                  errors++; $display("FAIL sb_unexpected if_ready=%b dm_ready=%b", if_ready, dm_ready);
               end else begin
                  exp_t e;
                  e = sb.pop_front();
                  if (e.dm !== dm_ready) begin
                     errors++; $display("FAIL sb_port got_dm=%b want_dm=%b", dm_ready, e.dm);
                  end else if (e.dm) begin
                     if (!e.wr) exp_dm = e.data;
                     if (dm_rdata !== exp_dm) begin errors++; $display("FAIL sb_dm_rdata got=%h want=%h", dm_rdata, exp_dm); end
                  end else begin
                     exp_if = e.data;
                     if (if_rdata !== exp_if) begin errors++; $display("FAIL sb_if_rdata got=%h want=%h", if_rdata, exp_if); end
                  end
               end
            end
         end
      join_none
      test_reset;
      test_if_read;
      test_write_read;
      test_starve;
      test_withdraw;
`ifdef ALIGN_CHECK_EN
      test_align;
`endif
      test_reset_mid_write;
      repeat (3) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover got=%0d want=0", sb.size()); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
